// File: rtl/eq2_exerciser.sv
// Self-test driver for a 1-bit equality comparator: steps through four fixed (x,y) vectors and counts mismatches.
// Optional build macro EQ2EX_STOP_ON_FAIL_EN ends a run at the first mismatching vector.
module eq2_exerciser #(
  parameter int unsigned HOLD_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       s_in,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] vec_idx
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic       w_mismatch;
  logic       w_stop;
  logic [2:0] w_err_nxt;
  logic [1:0] w_idx_nxt;

  // Expected comparator result is ~(x^y) of the operands currently driven.
  assign w_mismatch = (s_in != ~(x ^ y));
  assign w_err_nxt  = err_cnt + 3'(w_mismatch);
  assign w_idx_nxt  = vec_idx + 2'd1;

`ifdef EQ2EX_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  // Vector table (0,0),(1,0),(1,1),(0,1) is x = idx[1]^idx[0], y = idx[1].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      x       <= 1'b0;
      y       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
      vec_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_APPLY;
            r_cnt   <= '0;
            vec_idx <= 2'd0;
            x       <= 1'b0;
            y       <= 1'b0;
            busy    <= 1'b1;
            err_cnt <= '0;
          end
        end
        S_APPLY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          err_cnt <= w_err_nxt;
          if ((vec_idx == 2'd3) || w_stop) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (w_err_nxt == 3'd0);
          end else begin
            r_state <= S_APPLY;
            r_cnt   <= '0;
            vec_idx <= w_idx_nxt;
            x       <= w_idx_nxt[1] ^ w_idx_nxt[0];
            y       <= w_idx_nxt[1];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq2_exerciser.sv
// Randomized bench for eq2_exerciser: two instances (HOLD_CYCLES 50 and 2) checked every cycle against a run-timeline model.
module tb_eq2_exerciser;

  localparam int unsigned H0 = 50;
  localparam int unsigned H1 = 2;

`ifdef EQ2EX_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      start;
  logic [1:0]      s_in;
  logic [1:0]      x, y, busy, done, pass;
  logic [1:0][2:0] err_cnt;
  logic [1:0][1:0] vec_idx;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  eq2_exerciser #(.HOLD_CYCLES(H0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .s_in(s_in[0]),
    .x(x[0]), .y(y[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_cnt(err_cnt[0]), .vec_idx(vec_idx[0])
  );

  eq2_exerciser #(.HOLD_CYCLES(H1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .s_in(s_in[1]),
    .x(x[1]), .y(y[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_cnt(err_cnt[1]), .vec_idx(vec_idx[1])
  );

  // Reference model: position inside a run counted in cycles since the accepting edge.
  bit x_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  bit y_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  int hold  [2] = '{int'(H0), int'(H1)};
  bit m_act [2];
  bit m_done[2];
  bit m_pass[2];
  int m_k   [2];
  int m_idx [2];
  int m_err [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_done[d] = 0; m_pass[d] = 0;
      m_k[d] = 0; m_idx[d] = 0; m_err[d] = 0;
    end
  endtask

  function automatic bit is_check_cycle(input int d);
    return m_act[d] && (m_k[d] % hold[d] == 0);
  endfunction

  function automatic bit exp_s(input int d);
    return (x_tab[m_idx[d]] == y_tab[m_idx[d]]);
  endfunction

  task automatic model_edge(input int d, input bit st, input bit s);
    bit miss;
    if (!rst_n) begin
      m_act[d] = 0; m_done[d] = 0; m_pass[d] = 0;
      m_k[d] = 0; m_idx[d] = 0; m_err[d] = 0;
    end else if (m_done[d]) begin
      m_done[d] = 0;
    end else if (!m_act[d]) begin
      if (st) begin
        m_act[d] = 1; m_k[d] = 1; m_idx[d] = 0; m_err[d] = 0;
      end
    end else begin
      if (is_check_cycle(d)) begin
        miss = (s != exp_s(d));
        if (miss) m_err[d]++;
        if (m_idx[d] == 3 || (STOP && miss)) begin
          m_act[d]  = 0;
          m_done[d] = 1;
          m_pass[d] = (m_err[d] == 0);
        end else begin
          m_idx[d]++;
        end
      end
      m_k[d]++;
    end
  endtask

  task automatic compare(input int d);
    logic [9:0] obs, exp;
    obs = {x[d], y[d], busy[d], done[d], pass[d], err_cnt[d], vec_idx[d]};
    exp = {x_tab[m_idx[d]], y_tab[m_idx[d]], m_act[d], m_done[d], m_pass[d],
           3'(m_err[d]), 2'(m_idx[d])};
    check_val($sformatf("dut%0d_outs", d), 32'(obs), 32'(exp));
  endtask

  // mode 0: correct at CHECK, random glitches elsewhere; 1: tied high; 2: fully random
  function automatic bit s_drive(input int d, input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 0 && is_check_cycle(d)) return exp_s(d);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cycle(input bit st0, input bit st1, input bit s0, input bit s1);
    start[0] = st0; start[1] = st1; s_in[0] = s0; s_in[1] = s1;
    @(posedge clk);
    model_edge(0, st0, s0);
    model_edge(1, st1, s1);
    #1;
    compare(0);
    compare(1);
    @(negedge clk);
  endtask

  // One run on instance d; negative expectations skip the matching end-of-run check.
  task automatic run(input int d, input int mode, input bit extra_starts, input int abort_at,
                     input int exp_done, input int exp_err, input int exp_pass, input int exp_idx);
    int  done_at;
    bit  st;
    done_at = -1;
    cycle(d == 0, d == 1, s_drive(0, d == 0 ? mode : 2), s_drive(1, d == 1 ? mode : 2));
    for (int n = 1; n <= 4 * hold[d] + 4; n++) begin
      if (done[d] && done_at < 0) done_at = n;
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare(0);
        compare(1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
      end
      st = extra_starts && (n == 30 || n == 150);
      cycle(d == 0 && st, d == 1 && st,
            s_drive(0, d == 0 ? mode : 2), s_drive(1, d == 1 ? mode : 2));
    end
    if (exp_done != -2) check_val($sformatf("dut%0d_done_cycle", d), 32'(done_at), 32'(exp_done));
    if (exp_err  >= 0)  check_val($sformatf("dut%0d_err_cnt", d), 32'(err_cnt[d]), 32'(exp_err));
    if (exp_pass >= 0)  check_val($sformatf("dut%0d_pass", d), 32'(pass[d]), 32'(exp_pass));
    if (exp_idx  >= 0)  check_val($sformatf("dut%0d_vec_idx", d), 32'(vec_idx[d]), 32'(exp_idx));
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    s_in  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare(0);
    compare(1);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 1'b1);

    // Clean run with glitches outside CHECK
    run(0, 0, 1'b0, -1, 4 * H0 + 1, 0, 1, 3);
    // s_in stuck high: idx1 and idx3 fail
    if (STOP) run(0, 1, 1'b0, -1, 2 * H0 + 1, 1, 0, 1);
    else      run(0, 1, 1'b0, -1, 4 * H0 + 1, 2, 0, 3);
    // Restart requests during a run are ignored
    run(0, 0, 1'b1, -1, 4 * H0 + 1, 0, 1, 3);
    // Reset mid-run aborts without a done pulse, then a fresh run
    run(0, 0, 1'b0, 120, -1, 0, 0, 0);
    run(0, 0, 1'b0, -1, 4 * H0 + 1, 0, 1, 3);

    // Minimum hold length
    run(1, 0, 1'b0, -1, 4 * H1 + 1, 0, 1, 3);
    if (STOP) run(1, 1, 1'b0, -1, 2 * H1 + 1, 1, 0, 1);
    else      run(1, 1, 1'b0, -1, 4 * H1 + 1, 2, 0, 3);
    for (int r = 0; r < 20; r++) run(1, 2, 1'b0, -1, -2, -1, -1, -1);
    run(0, 2, 1'b0, -1, -2, -1, -1, -1);

    // Free-running random starts and s_in on both instances
    for (int i = 0; i < 1200; i++) begin
      cycle(($urandom % 16) == 0, ($urandom % 8) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
